// File: rtl/sprite_rom_arbiter.sv
// Two-requester arbiter for a single sprite ROM port; grant-to-vld latency is ROM_LAT+1 cycles.
// Strict A priority by default; define ARB_FAIRNESS_EN to promote B after STARVE_MAX denied cycles.
module sprite_rom_arbiter #(
  parameter int AW         = 15,
  parameter int DW         = 12,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic          a_gnt,
  output logic          a_vld,
  output logic [DW-1:0] a_data,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic          b_gnt,
  output logic          b_vld,
  output logic [DW-1:0] b_data,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);

  logic                w_promote;
  logic                w_exit_vld;
  logic                w_exit_own;
  logic [AW-1:0]       r_rom_addr;
  logic [ROM_LAT-1:0]  r_tag_vld;
  logic [ROM_LAT-1:0]  r_tag_own;
  logic                r_a_vld;
  logic                r_b_vld;
  logic [DW-1:0]       r_a_data;
  logic [DW-1:0]       r_b_data;

`ifdef ARB_FAIRNESS_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] r_starve;

  assign w_promote = (r_starve == SW'(STARVE_MAX));

  // Saturates at STARVE_MAX; clears once B wins or drops its request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_starve <= '0;
    else if (!b_req || b_gnt) r_starve <= '0;
    else if (!w_promote)     r_starve <= r_starve + 1'b1;
  end
`else
  logic [31:0] w_unused_starve;
  assign w_unused_starve = STARVE_MAX;
  assign w_promote       = 1'b0;
`endif

  assign a_gnt    = !rst && a_req && !(b_req && w_promote);
  assign b_gnt    = !rst && b_req && !a_gnt;
  assign rom_addr = a_gnt ? a_addr : (b_gnt ? b_addr : r_rom_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rom_addr <= '0;
    else     r_rom_addr <= rom_addr;
  end

  // Owner tags travel alongside the ROM read so returns are routed in grant order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld <= '0;
      r_tag_own <= '0;
    end else begin
      r_tag_vld[0] <= a_gnt | b_gnt;
      r_tag_own[0] <= b_gnt;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
      end
    end
  end

  assign w_exit_vld = r_tag_vld[ROM_LAT-1];
  assign w_exit_own = r_tag_own[ROM_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_vld  <= 1'b0;
      r_b_vld  <= 1'b0;
      r_a_data <= '0;
      r_b_data <= '0;
    end else begin
      r_a_vld <= w_exit_vld && !w_exit_own;
      r_b_vld <= w_exit_vld &&  w_exit_own;
      if (w_exit_vld && !w_exit_own) r_a_data <= rom_data;
      if (w_exit_vld &&  w_exit_own) r_b_data <= rom_data;
    end
  end

  assign a_vld  = r_a_vld;
  assign b_vld  = r_b_vld;
  assign a_data = r_a_data;
  assign b_data = r_b_data;

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter AW, default 15, sprite ROM address width.
REQ-002 Parameter DW, default 12, sprite ROM data width (4:4:4 RGB).
REQ-003 Parameter ROM_LAT, default 1, ROM read latency in cycles (address registered to data valid), legal 1..4.
REQ-004 Parameter STARVE_MAX, default 4, consecutive denied cycles before requester B is promoted (used only with ARB_FAIRNESS_EN).
REQ-005 clk  in  1  single clock for the block and the attached ROM.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 a_req  in  1  requester A (VGA pixel fetch) read request.
REQ-008 a_addr  in  AW  requester A read address.
REQ-009 a_gnt  out  1  A's request accepted this cycle.
REQ-010 a_vld  out  1  one-cycle pulse, a_data holds A's returned word.
REQ-011 a_data  out  DW  last word returned to A.
REQ-012 b_req / b_addr / b_gnt / b_vld / b_data  same directions, widths and meaning as A, for requester B (hit/collision sampler).
REQ-013 rom_addr  out  AW  address to the ROM port.
REQ-014 rom_data  in  DW  ROM output, valid ROM_LAT cycles after rom_addr is sampled.

Function
REQ-015 Grant is combinational in the request cycle; at most one of a_gnt, b_gnt is high in any cycle.
REQ-016 Sole requester is always granted; with both requesting, A wins unless promotion (REQ-025) is active.
REQ-017 rom_addr equals the granted requester's address in the grant cycle; with no grant, rom_addr holds its previous value.
REQ-018 An owner tag pipeline ROM_LAT stages deep (valid + owner bit) records every grant.
REQ-019 When a tag exits the pipeline, rom_data is registered into that owner's x_data and x_vld pulses high the following cycle; total latency grant-to-vld = ROM_LAT+1 cycles.
REQ-020 Back-to-back grants (any interleave of A and B) are supported at one per cycle; returns appear in grant order, each with exactly one vld pulse.
REQ-021 a_vld and b_vld are never high in the same cycle.
REQ-022 x_data is held unchanged between that requester's vld pulses.
REQ-023 Requests are not queued: a denied requester must hold req and addr; no data is returned for a denied cycle.

Reset
REQ-024 While rst is high: a_gnt=b_gnt=0, a_vld=b_vld=0, a_data=b_data=0, rom_addr=0, all tags invalid, starvation counter=0; reset mid-operation discards in-flight reads, and no vld pulse for them appears after release.

Configuration
REQ-025 Macro ARB_FAIRNESS_EN defined: a saturating counter increments each cycle b_req=1 and b_gnt=0, clears when b_gnt=1 or b_req=0; when it equals STARVE_MAX, B wins the next contested cycle and the counter clears.
REQ-026 Macro ARB_FAIRNESS_EN undefined: strict A priority, no counter logic present, B can starve indefinitely.

Verification
REQ-027 a_req=1 alone, a_addr=0x0123, ROM_LAT=1 -> a_gnt same cycle, rom_addr=0x0123, a_vld pulse 2 cycles later with a_data=ROM[0x0123]; b_vld stays 0.
REQ-028 a_req and b_req both high 1 cycle, fairness off -> a_gnt=1, b_gnt=0; B held for next cycle with A idle -> b_gnt=1, b_vld 2 cycles after that.
REQ-029 Alternating grants A,B,A,B at addresses 0x10,0x20,0x30,0x40 -> vld pulses A,B,A,B on consecutive cycles with matching ROM words, never overlapping.
REQ-030 ARB_FAIRNESS_EN, STARVE_MAX=4, both requesting continuously -> A granted 4 cycles, B granted on 5th, pattern repeats; without macro B never granted.
REQ-031 rst asserted one cycle after an A grant -> outputs zero asynchronously, no a_vld for that read after release, first post-reset request serves normally.
